// File: rtl/tag_pkg.sv
// Shared types and geometry for the 4-way tag lookup controller.
// Address split: tag [31:14], set [13:6], offset [5:0].
package tag_pkg;

  localparam int TAG_W = 18;
  localparam int SET_W = 8;
  localparam int WAYS  = 4;
  localparam int OFF_W = 6;
  localparam int WAY_W = 2;
  localparam int SETS  = 1 << SET_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESP
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic [OFF_W-1:0] off;
  } addr_t;

  // Lowest way whose valid bit is clear (0 when all are set).
  function automatic logic [WAY_W-1:0] first_free(
    input logic [WAYS-1:0] v
  );
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!v[i]) r = i[WAY_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_compare4.sv
// Combinational 4-way tag compare with lowest-way priority.
// Ways are qualified by their valid bits before matching.
module tag_compare4
  import tag_pkg::*;
(
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WAYS-1:0]       valid,
  output logic                  hit,
  output logic [WAY_W-1:0]      way
);

  logic [WAYS-1:0] match;

  // Per-way match, masked by the set's valid bits.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[w] &&
                 (tags[w*TAG_W +: TAG_W] == tag);
    end
  end

  // Priority encode: the lowest matching way wins.
  always_comb begin
    hit = |match;
    way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) way = w[WAY_W-1:0];
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// 4-way set-associative tag lookup controller with fill and invalidate.
// Define TAG_LOOKUP_STATS_EN to add saturating hit/miss counters.
module tag_lookup_ctrl
  import tag_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_fill,
  input  logic              inv_all,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [SET_W-1:0]  ram_r_index,
  input  logic [71:0]       ram_tag_out,
  output logic [9:0]        ram_w_index,
  output logic [TAG_W-1:0]  ram_tag_in,
  output logic              ram_wr_en
`ifdef TAG_LOOKUP_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  state_t state_q, state_d;
  addr_t  req_a;

  logic [TAG_W-1:0] tag_q;
  logic [SET_W-1:0] set_q;
  logic             fill_q;
  logic             hit_q;
  logic [WAY_W-1:0] way_q;

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;

  logic [WAYS-1:0]  set_valid;
  logic             cmp_hit;
  logic [WAY_W-1:0] cmp_way;
  logic [WAY_W-1:0] victim;
  logic             set_full;
  logic             unused_off;

  assign req_a      = addr_t'(req_addr);
  assign unused_off = ^req_a.off;
  assign set_valid  = valid_q[set_q];
  assign set_full   = &set_valid;
  assign victim     = set_full ? rr_q[set_q]
                               : first_free(set_valid);

  tag_compare4 u_cmp (
    .tag   (tag_q),
    .tags  (ram_tag_out),
    .valid (set_valid),
    .hit   (cmp_hit),
    .way   (cmp_way)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and all handshake / RAM outputs.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_hit    = 1'b0;
    resp_way    = '0;
    ram_r_index = set_q;
    ram_wr_en   = 1'b0;
    ram_w_index = '0;
    ram_tag_in  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready   = 1'b1;
        ram_r_index = req_a.set;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (!cmp_hit && fill_q) state_d = FILL;
        else                    state_d = RESP;
      end
      FILL: begin
        ram_wr_en   = 1'b1;
        ram_w_index = {set_q, victim};
        ram_tag_in  = tag_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_way   = way_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      set_q  <= '0;
      fill_q <= 1'b0;
      hit_q  <= 1'b0;
      way_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            tag_q  <= req_a.tag;
            set_q  <= req_a.set;
            fill_q <= req_fill;
          end
        end
        LOOKUP: begin
          hit_q <= cmp_hit;
          way_q <= cmp_hit ? cmp_way : '0;
        end
        FILL:    way_q <= victim;
        default: ;
      endcase
    end
  end

  // Valid bits and round-robin pointers; invalidate beats a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      if (state_q == FILL && set_full)
        rr_q[set_q] <= rr_q[set_q] + 2'd1;
      if (inv_all)
        valid_q <= '0;
      else if (state_q == FILL)
        valid_q[set_q][victim] <= 1'b1;
    end
  end

`ifdef TAG_LOOKUP_STATS_EN
  // Saturating hit/miss counters, one count per response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (inv_all) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == RESP) begin
      if (hit_q) begin
        if (hit_count != '1)
          hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1)
          miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
